// File: rtl/aes_engine_pkg.sv
// aes_engine_pkg: shared width, scheduler state encoding and requester id type
package aes_engine_pkg;
  localparam int BLOCK_W = 128;
  typedef enum logic [2:0] {IDLE, RUN, RELEASE, WAIT_CLR, RESP} state_t;
  typedef logic req_id_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; ties go to the requester not served last
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_,
  input  logic [1:0] valid,
  input  logic       prev_grant,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       last_grant
);
  logic last_grant_q, last_grant_d;
  always_comb begin
    grant = &valid ? (prev_grant ? 2'b01 : 2'b10) : valid;
    last_grant_d = accept ? grant[1] : last_grant_q;
  end
  always_ff @(posedge clk) last_grant_q <= rst_ ? 1'b1 : last_grant_d;
  assign last_grant = last_grant_q;
endmodule

// File: rtl/aes_transformer_scheduler.sv
// aes_transformer_scheduler: shares one round transformer between two requesters,
// drives its start/done/output_read handshake and returns tagged results with a watchdog abort.
module aes_transformer_scheduler #(
  parameter int BLOCK_W        = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [BLOCK_W-1:0] req0_data,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [BLOCK_W-1:0] req1_data,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [BLOCK_W-1:0] resp_data,
  output logic               resp_error,
  output logic [BLOCK_W-1:0] plaintext,
  output logic               transformer_start,
  input  logic               transformer_done,
  output logic               output_read,
  input  logic [BLOCK_W-1:0] ciphertext,
  output logic               busy
);
  import aes_engine_pkg::*;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [BLOCK_W-1:0] plaintext_q, plaintext_d, resp_data_q, resp_data_d;
  req_id_t owner_q, owner_d;
  logic err_q, err_d;
  logic [1:0] grant;
  logic last_grant, accept, wd_exp;
  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_      (rst_),
    .valid     ({req1_valid, req0_valid}),
    .prev_grant(last_grant),
    .accept    (accept),
    .grant     (grant),
    .last_grant(last_grant)
  );
  assign accept = (state_q == IDLE) && |grant;
  // expiry is judged on the cycle whose increment would reach TIMEOUT_CYCLES
  assign wd_exp = wd_q >= WD_LAST;
  always_comb begin
    state_d = state_q;
    wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
    plaintext_d = plaintext_q;
    resp_data_d = resp_data_q;
    owner_d = owner_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = RUN;
        plaintext_d = grant[1] ? req1_data : req0_data;
        owner_d = grant[1];
        wd_d = '0;
      end
      RUN: if (transformer_done || wd_exp) begin
        state_d = RELEASE;
        resp_data_d = transformer_done ? ciphertext : '0;
        err_d = !transformer_done;
      end
      RELEASE: begin
        state_d = WAIT_CLR;
        wd_d = '0;
      end
      WAIT_CLR: if (!transformer_done) state_d = RESP;
      else if (wd_exp) begin
        state_d = RESP;
        resp_data_d = '0;
        err_d = 1'b1;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= IDLE;
      wd_q <= '0;
      plaintext_q <= '0;
      resp_data_q <= '0;
      owner_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q <= wd_d;
      plaintext_q <= plaintext_d;
      resp_data_q <= resp_data_d;
      owner_q <= owner_d;
      err_q <= err_d;
    end
  end
  assign req0_ready = (state_q == IDLE) && grant[0];
  assign req1_ready = (state_q == IDLE) && grant[1];
  assign transformer_start = state_q == RUN;
  assign output_read = state_q == RELEASE;
  assign resp_valid = state_q == RESP;
  assign busy = state_q != IDLE;
  assign plaintext = plaintext_q;
  assign resp_data = resp_data_q;
  assign resp_id = owner_q;
  assign resp_error = err_q;
endmodule

// File: tb/tb_aes_transformer_scheduler.sv
// tb_aes_transformer_scheduler: directed + randomized bench with a behavioural transformer
// and an expected-response queue; a second instance exercises the 8-cycle watchdog.
module tb_aes_transformer_scheduler;
  localparam int W = 128;
  localparam int LAT = 12;
  localparam int WD_TO = 8;
  typedef struct {
    logic         id;
    logic [W-1:0] data;
    logic         err;
  } rsp_t;
  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;
  logic req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, resp_valid, resp_id, resp_error, transformer_start, output_read, busy;
  logic [W-1:0] resp_data, plaintext, ciphertext;
  logic transformer_done = 1'b0;
  int tcnt = 0;
  logic w_req0_valid = 1'b0, w_resp_ready = 1'b0;
  logic [W-1:0] w_req0_data = '0;
  logic w_req0_ready, w_req1_ready, w_resp_valid, w_resp_id, w_resp_error, w_start, w_oread, w_busy;
  logic [W-1:0] w_resp_data, w_plaintext, w_ciphertext;
  logic w_done = 1'b0;
  int w_cnt = 0;
  int w_lat = 0;
  int vectors = 0, miscompares = 0;
  rsp_t exp_q[$];
  logic exp_last = 1'b1;

  aes_transformer_scheduler dut (
    .clk(clk), .rst_(rst_),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_error(resp_error), .plaintext(plaintext),
    .transformer_start(transformer_start), .transformer_done(transformer_done),
    .output_read(output_read), .ciphertext(ciphertext), .busy(busy)
  );

  aes_transformer_scheduler #(.BLOCK_W(W), .TIMEOUT_CYCLES(WD_TO)) dut_wd (
    .clk(clk), .rst_(rst_),
    .req0_valid(w_req0_valid), .req0_ready(w_req0_ready), .req0_data(w_req0_data),
    .req1_valid(1'b0), .req1_ready(w_req1_ready), .req1_data('0),
    .resp_valid(w_resp_valid), .resp_ready(w_resp_ready), .resp_id(w_resp_id),
    .resp_data(w_resp_data), .resp_error(w_resp_error), .plaintext(w_plaintext),
    .transformer_start(w_start), .transformer_done(w_done),
    .output_read(w_oread), .ciphertext(w_ciphertext), .busy(w_busy)
  );

  // transformer model: done LAT cycles after start rises, dropped after output_read
  always @(posedge clk)
    if (rst_ || output_read) begin
      transformer_done <= 1'b0;
      tcnt <= 0;
    end else if (transformer_start && !transformer_done) begin
      tcnt <= tcnt + 1;
      if (tcnt + 1 == LAT) transformer_done <= 1'b1;
    end
  assign ciphertext = ~plaintext;

  // same model for the watchdog instance; w_lat == 0 means done never comes
  always @(posedge clk)
    if (rst_ || w_oread) begin
      w_done <= 1'b0;
      w_cnt <= 0;
    end else if (w_start && !w_done) begin
      w_cnt <= w_cnt + 1;
      if (w_cnt + 1 == w_lat) w_done <= 1'b1;
    end
  assign w_ciphertext = ~w_plaintext;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic issue(input logic v0, input logic v1, input logic [W-1:0] d0, input logic [W-1:0] d1);
    logic g;
    rsp_t e;
    g = (v0 && v1) ? !exp_last : v1;
    req0_valid = v0;
    req1_valid = v1;
    req0_data = d0;
    req1_data = d1;
    #1;
    chk("req0_ready", req0_ready, !g);
    chk("req1_ready", req1_ready, g);
    @(negedge clk);
    if (g) req1_valid = 1'b0;
    else req0_valid = 1'b0;
    chk("start_after_accept", transformer_start, 1);
    chk("busy_run", busy, 1);
    chk("plaintext", plaintext, g ? d1 : d0);
    exp_last = g;
    e.id = g;
    e.data = ~(g ? d1 : d0);
    e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic finish_resp(input int hold, input bit pre);
    rsp_t e;
    int n;
    n = 0;
    e = exp_q.pop_front();
    resp_ready = pre;
    while (!resp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("resp_arrives", resp_valid, 1);
    chk("resp_id", resp_id, e.id);
    chk("resp_data", resp_data, e.data);
    chk("resp_error", resp_error, e.err);
    if (!pre) begin
      repeat (hold) begin
        @(negedge clk);
        chk("hold_valid", resp_valid, 1);
        chk("hold_data", resp_data, e.data);
        chk("hold_id", resp_id, e.id);
        chk("hold_no_accept", {req1_ready, req0_ready}, 0);
      end
      resp_ready = 1'b1;
    end
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", resp_valid, 0);
    chk("back_idle", busy, 0);
  endtask

  task automatic wd_run(input int lat);
    logic [W-1:0] d;
    int n, done_cyc, exp_n;
    logic exp_err;
    done_cyc = (lat == 0) ? 1000 : lat + 1;
    exp_err = done_cyc > WD_TO;
    exp_n = exp_err ? WD_TO : done_cyc;
    w_lat = lat;
    d = rnd();
    w_req0_data = d;
    w_req0_valid = 1'b1;
    #1;
    chk("w_ready", w_req0_ready, 1);
    @(negedge clk);
    w_req0_valid = 1'b0;
    n = 0;
    while (!w_oread && n < 50) begin
      chk("w_start_held", w_start, 1);
      @(negedge clk);
      n++;
    end
    chk("w_run_cycles", n, exp_n);
    chk("w_start_low_release", w_start, 0);
    @(negedge clk);
    chk("w_oread_single", w_oread, 0);
    n = 0;
    while (!w_resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("w_resp_arrives", w_resp_valid, 1);
    chk("w_resp_error", w_resp_error, exp_err);
    chk("w_resp_data", w_resp_data, exp_err ? '0 : ~d);
    chk("w_resp_id", w_resp_id, 0);
    w_resp_ready = 1'b1;
    @(negedge clk);
    w_resp_ready = 1'b0;
    chk("w_resp_drop", w_resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    logic [1:0] v;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", transformer_start, 0);
    chk("rst_oread", output_read, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_readies", {req1_ready, req0_ready}, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_plaintext", plaintext, 0);
    chk("rst_id_err", {resp_id, resp_error}, 0);
    rst_ = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_start", transformer_start, 0);
    chk("idle_readies", {req1_ready, req0_ready}, 0);

    issue(1'b1, 1'b0, 128'h00041214120412000C00131108231919, '0);
    n = 0;
    while (!output_read && n < 100) begin
      chk("start_held", transformer_start, 1);
      @(negedge clk);
      n++;
    end
    chk("run_cycles", n, LAT + 1);
    chk("release_start_low", transformer_start, 0);
    @(negedge clk);
    chk("oread_one_cycle", output_read, 0);
    chk("waitclr_no_resp", resp_valid, 0);
    @(negedge clk);
    chk("resp_after_clr", resp_valid, 1);
    chk("s2_ct", resp_data, 128'hFFFBEDEBEDFBEDFFF3FFECEEF7DCE6E6);
    finish_resp(0, 1'b0);

    rst_ = 1'b1;
    @(negedge clk);
    rst_ = 1'b0;
    exp_last = 1'b1;
    issue(1'b1, 1'b1, rnd(), rnd());
    finish_resp(0, 1'b0);
    issue(1'b1, 1'b1, rnd(), req1_data);
    finish_resp(0, 1'b0);
    issue(1'b1, 1'b1, rnd(), rnd());
    finish_resp(0, 1'b0);

    issue(1'b1, 1'b0, rnd(), '0);
    req1_valid = 1'b1;
    req1_data = rnd();
    finish_resp(5, 1'b0);
    issue(1'b0, 1'b1, '0, req1_data);
    finish_resp(0, 1'b1);

    issue(1'b1, 1'b0, rnd(), '0);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    rst_ = 1'b0;
    exp_last = 1'b1;
    chk("rst_run_start", transformer_start, 0);
    chk("rst_run_busy", busy, 0);
    chk("rst_run_oread", output_read, 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += resp_valid;
    end
    chk("rst_run_no_resp", n, 0);
    issue(1'b1, 1'b0, rnd(), '0);
    finish_resp(0, 1'b0);

    repeat (10) begin
      v = 2'($urandom_range(1, 3));
      issue(v[0], v[1], rnd(), rnd());
      finish_resp($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    wd_run(0);
    wd_run(8);
    wd_run(7);
    wd_run(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/aes_transformer_scheduler.md
# aes_transformer_scheduler

Scheduler that shares the single `engine_round_transformer` between two plaintext requesters. It arbitrates round-robin, launches the transformer through its `transformer_start` / `transformer_done` / `output_read` handshake, and captures the ciphertext. It returns the result, tagged with the requester id, on a valid/ready response port. A watchdog aborts a run whose `transformer_done` never arrives. The round keys are wired to the transformer directly by the key schedule and are not handled here.

## Interface

**Parameters**

- `BLOCK_W`, 128: plaintext/ciphertext width.
- `TIMEOUT_CYCLES`, 64: maximum cycles spent in RUN or WAIT_CLR before abort; legal range 2..65535.

**Ports** (name, direction, width, meaning)

- `clk`, in, 1: single clock, rising edge.
- `rst_`, in, 1: synchronous reset, active-high, sampled on `clk`.
- `req0_valid`, in, 1: requester 0 has a block.
- `req0_ready`, out, 1: requester 0 block is accepted this cycle.
- `req0_data`, in, BLOCK_W: requester 0 plaintext.
- `req1_valid`, `req1_ready`, `req1_data`: same meaning, for requester 1.
- `resp_valid`, out, 1: result available.
- `resp_ready`, in, 1: consumer takes the result.
- `resp_id`, out, 1: requester that owns the result.
- `resp_data`, out, BLOCK_W: captured ciphertext.
- `resp_error`, out, 1: run aborted by the watchdog; `resp_data` is all-zero.
- `plaintext`, out, BLOCK_W: connects to the transformer `plaintext`.
- `transformer_start`, out, 1: connects to the transformer `transformer_start`.
- `transformer_done`, in, 1: connects to the transformer `transformer_done`.
- `output_read`, out, 1: connects to the transformer `output_read`.
- `ciphertext`, in, BLOCK_W: connects to the transformer `ciphertext`.
- `busy`, out, 1: high in any state other than IDLE.

## Operation

**States and transitions**

- IDLE: arbitrating.
  - Accept on `reqN_valid && reqN_ready`.
  - Register `reqN_data` into `plaintext` and the id into the owner register.
  - Next state is RUN.
- RUN: `transformer_start` = 1; watchdog counts.
  - `transformer_done` = 1 → capture `ciphertext` into `resp_data`, clear the error flag, go to RELEASE.
  - Watchdog reaches `TIMEOUT_CYCLES` without done → set the error flag, zero `resp_data`, go to RELEASE.
- RELEASE: `transformer_start` = 0 and `output_read` = 1, for exactly one cycle. Next state is WAIT_CLR.
- WAIT_CLR: wait for `transformer_done` = 0, then go to RESP.
  - If done stays high for `TIMEOUT_CYCLES`, set the error flag and go to RESP anyway.
- RESP: `resp_valid` = 1 and its payload is held stable until `resp_ready`. On handshake, go to IDLE.

**Arbitration**

- `reqN_ready` = (state == IDLE) && (grant == N), computed combinationally.
- grant = the only valid requester. If both are valid, grant = the requester other than `last_grant`.
- `last_grant` updates on accept. Its reset value is 1, so requester 0 wins the first tie.
- With no request valid, both readies are 0.

**Watchdog**

- Counter width is $clog2(TIMEOUT_CYCLES+1).
- Cleared on entry to RUN and on entry to WAIT_CLR.
- Saturates; it never wraps.

**Boundary rules**

- Done and timeout in the same cycle: done wins (no error).
- A new request arriving during RUN..RESP is not accepted; its valid must be held by the requester.
- `resp_ready` already high on RESP entry: the response completes in one cycle.
- Reset mid-operation: next edge goes to IDLE and drops `transformer_start`/`output_read`. Any in-flight result is discarded with no response. The transformer is reset by its own `rst_`.

## Timing

**Reset values**

- All outputs 0; `plaintext`/`resp_data` all-zero.
- State IDLE; `last_grant` = 1.

**Latencies**

- Accept edge → `transformer_start` high on the next cycle (RUN).
- Done sampled high at edge k → `output_read` high during cycle k+1 → WAIT_CLR at k+2.
- `resp_valid` rises one cycle after `transformer_done` is sampled low in WAIT_CLR.
- Minimum occupancy per block is transformer latency + 4 cycles.

`transformer_start` stays high continuously from RUN entry until RELEASE, never pulsed.

## Structure

- Shared package `aes_engine_pkg`: `BLOCK_W`, the state enum (IDLE, RUN, RELEASE, WAIT_CLR, RESP), and the `req_id_t` typedef.
- Sub-module `rr_arbiter2`: inputs are two valid bits, `last_grant` and an accept strobe. Outputs are the one-hot grant and the registered `last_grant`.
- Top file holds the FSM, watchdog, capture registers and transformer handshake.

## Test plan

The bench uses a behavioural transformer model:
- asserts `transformer_done` 12 cycles after `transformer_start` rises;
- drives `ciphertext` = ~`plaintext`;
- drops done one cycle after `output_read`.

Scenarios:

1. Reset held 2 cycles → every output 0, `busy` 0; release, no requests → still idle.
2. req0 = 00041214120412000C00131108231919 → `resp_id` 0, `resp_data` FFFBEDEBEDFBEDFFF3FFECEEF7DCE6E6, `resp_error` 0; check the cycle counts in Timing.
3. req0 and req1 valid together from reset → req0 served first, then req1. Both held valid again → order 1, 0 (alternation).
4. Model never asserts done, `TIMEOUT_CYCLES` = 8 → `output_read` pulses once after 8 RUN cycles; response has `resp_error` 1 and `resp_data` 0.
5. `resp_ready` held low 5 cycles in RESP → payload stable, no new accept. Done coinciding with watchdog expiry → `resp_error` 0.
6. `rst_` asserted in RUN → `transformer_start` low next cycle, no response; a subsequent request completes normally.
